// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer.
// - redir_op_e : redirect op encodings driven by decode/branch-resolve
// - DEF_*      : default reset PC, exception vector and return-stack depth
// - sext16_word: sign-extend a 16-bit word offset to a 32-bit byte offset
package pc_pkg;

  typedef enum logic [2:0] {
    OP_SEQ   = 3'b000,
    OP_BR    = 3'b001,
    OP_J     = 3'b010,
    OP_JAL   = 3'b011,
    OP_JR    = 3'b100,
    OP_JR_RA = 3'b101,
    OP_EXC   = 3'b110,
    OP_RSVD  = 3'b111
  } redir_op_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  // Word offset -> byte offset: sign-extend and shift left by two.
  function automatic logic [31:0] sext16_word(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack, circular buffer of RAS_DEPTH entries.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_push, i_push_data push a return address (overwrites oldest when full)
//   i_pop               pop the top entry (ignored when empty)
//   i_clear             drop all entries
//   o_top               most recently pushed live entry
//   o_empty, o_full     occupancy flags
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [31:0] i_push_data,
  input  logic        i_pop,
  input  logic        i_clear,
  output logic [31:0] o_top,
  output logic        o_empty,
  output logic        o_full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [31:0]     r_mem [RAS_DEPTH];
  logic [PtrW-1:0] r_ptr;  // next slot to write
  logic [CntW-1:0] r_cnt;
  logic [PtrW-1:0] w_top_idx;

  // Pointer arithmetic wraps naturally since RAS_DEPTH is a power of two.
  assign w_top_idx = r_ptr - PtrW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CntMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= r_ptr + PtrW'(1);
      // Count saturates; the oldest entry is silently overwritten.
      if (r_cnt != CntMax) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end else if (i_pop && (r_cnt != '0)) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC generator with stall hold, one-entry pending redirect and
// a return-address stack that checks JR_RA predictions.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_stall              hold pc this cycle
//   i_redir_valid        redirect request (one pulse per instruction)
//   i_redir_op           redirect op (pc_pkg::redir_op_e encoding)
//   i_redir_pc           PC of the redirecting instruction
//   i_imm16, i_imm26     branch word offset / jump index
//   i_reg_target         GPR value for JR / JR_RA
//   o_pc, o_pc4          fetch PC (registered) and pc + 4
//   o_pend_valid         a redirect is being held during stall
//   o_ras_empty/full     return stack occupancy
//   o_ras_mismatch       1-cycle pulse after a JR_RA whose popped entry was wrong
//   o_pc_misalign        pc not word aligned
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redir_valid,
  input  logic [2:0]  i_redir_op,
  input  logic [31:0] i_redir_pc,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_reg_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_pend_valid,
  output logic        o_ras_empty,
  output logic        o_ras_full,
  output logic        o_ras_mismatch,
  output logic        o_pc_misalign
);

  redir_op_e   w_op;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_push;
  logic        w_pop;
  logic        w_clear;
  logic [31:0] w_ras_top;

  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic        r_ras_mismatch;

  assign w_op = redir_op_e'(i_redir_op);

  always_comb begin
    w_redirect = 1'b0;
    w_target   = '0;
    if (i_redir_valid) begin
      unique case (w_op)
        OP_BR: begin
          w_redirect = 1'b1;
          w_target   = i_redir_pc + 32'd4 + sext16_word(i_imm16);
        end
        OP_J, OP_JAL: begin
          w_redirect = 1'b1;
          w_target   = {i_redir_pc[31:28], i_imm26, 2'b00};
        end
        // JR_RA always redirects to the GPR value; the stack is only a check.
        OP_JR, OP_JR_RA: begin
          w_redirect = 1'b1;
          w_target   = i_reg_target;
        end
        OP_EXC: begin
          w_redirect = 1'b1;
          w_target   = EXC_VEC;
        end
        OP_SEQ, OP_RSVD: begin
          w_redirect = 1'b0;
        end
      endcase
    end
  end

  // Stack side effects happen in the accept cycle, independent of stall.
  assign w_push  = i_redir_valid && (w_op == OP_JAL);
  assign w_pop   = i_redir_valid && (w_op == OP_JR_RA) && !o_ras_empty;
  assign w_clear = i_redir_valid && (w_op == OP_EXC);

  ras_stack #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_data(i_redir_pc + 32'd4),
    .i_pop      (w_pop),
    .i_clear    (w_clear),
    .o_top      (w_ras_top),
    .o_empty    (o_ras_empty),
    .o_full     (o_ras_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc           <= RESET_PC;
      r_pend_valid   <= 1'b0;
      r_pend_target  <= '0;
      r_ras_mismatch <= 1'b0;
    end else begin
      r_ras_mismatch <= w_pop && (w_ras_top != i_reg_target);
      if (!i_stall) begin
        // A redirect arriving now is newer than anything pending.
        if (w_redirect) begin
          r_pc <= w_target;
        end else if (r_pend_valid) begin
          r_pc <= r_pend_target;
        end else begin
          r_pc <= r_pc + 32'd4;
        end
        r_pend_valid <= 1'b0;
      end else if (w_redirect) begin
        r_pend_target <= w_target;
        r_pend_valid  <= 1'b1;
      end
    end
  end

  assign o_pc           = r_pc;
  assign o_pc4          = r_pc + 32'd4;
  assign o_pend_valid   = r_pend_valid;
  assign o_ras_mismatch = r_ras_mismatch;
  assign o_pc_misalign  = |r_pc[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] RstPc = 32'h0000_3000;
  localparam logic [31:0] ExcVec = 32'h0000_4180;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redir_valid;
  logic [2:0]  redir_op;
  logic [31:0] redir_pc;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        pend_valid;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_mismatch;
  logic        pc_misalign;

  pc_sequencer #(
    .RESET_PC (RstPc),
    .EXC_VEC  (ExcVec),
    .RAS_DEPTH(Depth)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_redir_valid (redir_valid),
    .i_redir_op    (redir_op),
    .i_redir_pc    (redir_pc),
    .i_imm16       (imm16),
    .i_imm26       (imm26),
    .i_reg_target  (reg_target),
    .o_pc          (pc),
    .o_pc4         (pc4),
    .o_pend_valid  (pend_valid),
    .o_ras_empty   (ras_empty),
    .o_ras_full    (ras_full),
    .o_ras_mismatch(ras_mismatch),
    .o_pc_misalign (pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: PC, pending slot, and the return stack as a plain queue
  // (back = most recent; dropping the front models overwrite-oldest).
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic [31:0] m_ras[$];
  logic        m_mism;

  task automatic model_reset();
    m_pc       = RstPc;
    m_pend     = 1'b0;
    m_pend_tgt = '0;
    m_ras.delete();
    m_mism     = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        redirect;
    logic [31:0] top;
    int          sx;
    redirect = 1'b0;
    tgt      = '0;
    m_mism   = 1'b0;
    if (redir_valid) begin
      sx = int'($signed(imm16));
      case (redir_op)
        3'd1: begin redirect = 1'b1; tgt = redir_pc + 32'd4 + 32'(sx * 4); end
        3'd2, 3'd3: begin redirect = 1'b1; tgt = (redir_pc & 32'hF000_0000) + 32'(imm26) * 4; end
        3'd4, 3'd5: begin redirect = 1'b1; tgt = reg_target; end
        3'd6: begin redirect = 1'b1; tgt = ExcVec; end
        default: redirect = 1'b0;
      endcase
      if (redir_op == 3'd3) begin
        m_ras.push_back(redir_pc + 32'd4);
        if (m_ras.size() > Depth) void'(m_ras.pop_front());
      end
      if (redir_op == 3'd5 && m_ras.size() > 0) begin
        top    = m_ras.pop_back();
        m_mism = (top != reg_target);
      end
      if (redir_op == 3'd6) m_ras.delete();
    end
    if (!stall) begin
      if (redirect) m_pc = tgt;
      else if (m_pend) m_pc = m_pend_tgt;
      else m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (redirect) begin
      m_pend     = 1'b1;
      m_pend_tgt = tgt;
    end
  endtask

  task automatic chk_model();
    chk("model_pc", pc, m_pc);
    chk("model_pc4", pc4, m_pc + 32'd4);
    chk("model_pend", 32'(pend_valid), 32'(m_pend));
    chk("model_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("model_full", 32'(ras_full), 32'(m_ras.size() == Depth));
    chk("model_mism", 32'(ras_mismatch), 32'(m_mism));
    chk("model_misalign", 32'(pc_misalign), 32'(m_pc[1:0] != 2'b00));
  endtask

  // One clock: apply inputs, step the model on the edge, compare 1 ns later.
  task automatic cycle(input logic st, input logic v, input logic [2:0] op,
                       input logic [31:0] rpc, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rt);
    stall       = st;
    redir_valid = v;
    redir_op    = op;
    redir_pc    = rpc;
    imm16       = i16;
    imm26       = i26;
    reg_target  = rt;
    @(posedge clk);
    model_step();
    #1;
    chk_model();
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [2:0]  op;
    logic [31:0] rpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic        e_pend;
    logic        e_empty;
    logic        e_full;
    logic        e_mism;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [2:0]  rop;
    logic [31:0] rrt;

    // stall valid op redir_pc imm16 imm26 reg_target | pc pend empty full mism
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd1, 32'h3010, 16'hFFFE, 26'h0, 32'h0, 32'h300C, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd1, 32'h3010, 16'h0004, 26'h0, 32'h0, 32'h3024, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 3'd1, 32'h3000, 16'h0040, 26'h0, 32'h0, 32'h3024, 1, 1, 0, 0});
    tbl.push_back('{1, 1, 3'd2, 32'h3104, 16'h0, 26'h0000C40, 32'h0, 32'h3024, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3024, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3024, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3100, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3104, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 3'd4, 32'h0, 16'h0, 26'h0, 32'h3300, 32'h3104, 1, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd4, 32'h0, 16'h0, 26'h0, 32'h3200, 32'h3200, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd7, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3204, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd4, 32'h0, 16'h0, 26'h0, 32'h3202, 32'h3202, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3206, 0, 1, 0, 0});
    // Five JALs into a 4-deep stack, then drain with correct predictions.
    tbl.push_back('{0, 1, 3'd3, 32'h3000, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd3, 32'h3010, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd3, 32'h3020, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd3, 32'h3030, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 3'd3, 32'h3040, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 3'd5, 32'h0, 16'h0, 26'h0, 32'h3044, 32'h3044, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd5, 32'h0, 16'h0, 26'h0, 32'h3034, 32'h3034, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd5, 32'h0, 16'h0, 26'h0, 32'h3024, 32'h3024, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd5, 32'h0, 16'h0, 26'h0, 32'h3014, 32'h3014, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd5, 32'h0, 16'h0, 26'h0, 32'h3004, 32'h3004, 0, 1, 0, 0});
    // Wrong prediction pulses once; EXC clears the stack.
    tbl.push_back('{0, 1, 3'd3, 32'h3000, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd5, 32'h0, 16'h0, 26'h0, 32'h5000, 32'h5000, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h5004, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 3'd3, 32'h5004, 16'h0, 26'h800, 32'h0, 32'h2000, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd6, 32'h0, 16'h0, 26'h0, 32'h0, 32'h4180, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h4184, 0, 1, 0, 0});

    rst_n       = 1'b0;
    stall       = 1'b0;
    redir_valid = 1'b0;
    redir_op    = 3'd0;
    redir_pc    = '0;
    imm16       = '0;
    imm26       = '0;
    reg_target  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, RstPc);
    chk("reset_pend", 32'(pend_valid), 32'd0);
    chk("reset_empty", 32'(ras_empty), 32'd1);
    chk("reset_full", 32'(ras_full), 32'd0);
    chk("reset_mism", 32'(ras_mismatch), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].st, tbl[i].v, tbl[i].op, tbl[i].rpc, tbl[i].i16, tbl[i].i26, tbl[i].rt);
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_pc4", i), pc4, tbl[i].e_pc + 32'd4);
      chk($sformatf("vec%0d_misalign", i), 32'(pc_misalign), 32'(tbl[i].e_pc[1:0] != 2'b00));
      chk($sformatf("vec%0d_pend", i), 32'(pend_valid), 32'(tbl[i].e_pend));
      chk($sformatf("vec%0d_empty", i), 32'(ras_empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_full", i), 32'(ras_full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d_mism", i), 32'(ras_mismatch), 32'(tbl[i].e_mism));
    end

    // Async reset while stalled with a pending redirect and a live stack entry.
    cycle(1'b1, 1'b1, 3'd3, 32'h3000, 16'h0, 26'h900, 32'h0);
    chk("pre_reset_pend", 32'(pend_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc, RstPc);
    chk("async_reset_pend", 32'(pend_valid), 32'd0);
    chk("async_reset_empty", 32'(ras_empty), 32'd1);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("post_reset_pc", pc, 32'h3004);

    // Random traffic against the model; JR_RA often predicts correctly.
    for (int n = 0; n < 2000; n++) begin
      rop = 3'($urandom_range(0, 7));
      rrt = $urandom;
      if (rop == 3'd5 && m_ras.size() > 0 && $urandom_range(0, 1) == 1) rrt = m_ras[$];
      else if ($urandom_range(0, 3) != 0) rrt = rrt & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1), rop,
            $urandom & 32'hFFFF_FFFC, 16'($urandom), 26'($urandom), rrt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
